// File: rtl/camac_cycle_sequencer.sv
// ISA-to-CAMAC dataway cycle sequencer with programmable strobe timing, timeout and abort.
// Optional CAMAC_SEQ_SYNC_INPUTS_EN adds 2-flop synchronisers on sel, tim and cx1.
module camac_cycle_sequencer #(
    parameter int unsigned ADDR_WIDTH     = 2,
    parameter int unsigned C1_CYCLES      = 4,
    parameter int unsigned GAP_CYCLES     = 2,
    parameter int unsigned C2_CYCLES      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [ADDR_WIDTH-1:0]      a,
    input  logic                       w,
    input  logic                       sel,
    input  logic                       tim,
    input  logic                       ie,
    input  logic                       cx1,
    output logic                       rdy,
    output logic                       c1,
    output logic                       c2,
    output logic                       sel2,
    output logic [(2**ADDR_WIDTH)-1:0] x,
    output logic                       xr,
    output logic                       irq,
    output logic                       err
);
    localparam int unsigned XW    = 2 ** ADDR_WIDTH;
    localparam int unsigned MAX_A = (C1_CYCLES > GAP_CYCLES) ? C1_CYCLES : GAP_CYCLES;
    localparam int unsigned MAX_B = (C2_CYCLES > TIMEOUT_CYCLES) ? C2_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CNT_W = $clog2(MAX_C + 1);

    localparam logic [CNT_W-1:0] C1_LD  = CNT_W'(C1_CYCLES);
    localparam logic [CNT_W-1:0] GAP_LD = CNT_W'(GAP_CYCLES);
    localparam logic [CNT_W-1:0] C2_LD  = CNT_W'(C2_CYCLES);
    localparam logic [CNT_W-1:0] TO_LD  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE, WAIT_DW, STROBE1, GAP, STROBE2, DONE, ERR
    } state_t;

    state_t                 state, state_n;
    logic [CNT_W-1:0]       cnt, cnt_n;
    logic [ADDR_WIDTH-1:0]  a_lat, a_n;
    logic                   w_lat, w_n;
    logic                   sel_s, tim_s, cx1_s;
    logic                   start;
    logic                   rdy_n, c1_n, c2_n, sel2_n, xr_n, irq_n, err_n;
    logic [XW-1:0]          x_n;

`ifdef CAMAC_SEQ_SYNC_INPUTS_EN
    logic [1:0] sel_q, tim_q, cx1_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q <= '1;
            tim_q <= '0;
            cx1_q <= '0;
        end else begin
            sel_q <= {sel_q[0], sel};
            tim_q <= {tim_q[0], tim};
            cx1_q <= {cx1_q[0], cx1};
        end
    end

    assign sel_s = sel_q[1];
    assign tim_s = tim_q[1];
    assign cx1_s = cx1_q[1];
`else
    assign sel_s = sel;
    assign tim_s = tim;
    assign cx1_s = cx1;
`endif

    function automatic logic [XW-1:0] onehot(input logic [ADDR_WIDTH-1:0] v);
        onehot    = '0;
        onehot[v] = 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            a_lat <= '0;
            w_lat <= 1'b0;
            rdy   <= 1'b1;
            c1    <= 1'b0;
            c2    <= 1'b0;
            sel2  <= 1'b0;
            x     <= '0;
            xr    <= 1'b0;
            irq   <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            a_lat <= a_n;
            w_lat <= w_n;
            rdy   <= rdy_n;
            c1    <= c1_n;
            c2    <= c2_n;
            sel2  <= sel2_n;
            x     <= x_n;
            xr    <= xr_n;
            irq   <= irq_n;
            err   <= err_n;
        end
    end

    // Abort via sel is honoured only before c1 rises; strobe states ignore sel.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (!sel_s) begin
                    state_n = WAIT_DW;
                    cnt_n   = TO_LD;
                end
            end
            WAIT_DW: begin
                if (sel_s) begin
                    state_n = IDLE;
                end else if (tim_s) begin
                    state_n = STROBE1;
                    cnt_n   = C1_LD;
                end else if (cnt <= ONE) begin
                    state_n = ERR;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt - ONE;
                end
            end
            STROBE1: begin
                if (cnt <= ONE) begin
                    state_n = GAP;
                    cnt_n   = GAP_LD;
                end else begin
                    cnt_n = cnt - ONE;
                end
            end
            GAP: begin
                if (cnt <= ONE) begin
                    if (w_lat) begin
                        state_n = STROBE2;
                        cnt_n   = C2_LD;
                    end else begin
                        state_n = DONE;
                        cnt_n   = '0;
                    end
                end else begin
                    cnt_n = cnt - ONE;
                end
            end
            STROBE2: begin
                if (cnt <= ONE) begin
                    state_n = DONE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt - ONE;
                end
            end
            DONE, ERR: begin
                if (sel_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they change on the same edge as the state.
    always_comb begin
        start  = (state == IDLE) && (state_n == WAIT_DW);
        a_n    = start ? a : a_lat;
        w_n    = start ? w : w_lat;
        rdy_n  = (state_n == IDLE) || (state_n == DONE) || (state_n == ERR);
        c1_n   = (state_n == STROBE1);
        c2_n   = (state_n == STROBE2);
        sel2_n = (state_n != IDLE);
        x_n    = sel2_n ? onehot(a_n) : '0;
        xr_n   = (state == STROBE1 && state_n == GAP) ? cx1_s : xr;
        if (start)
            irq_n = 1'b0;
        else if (state_n == DONE && state != DONE)
            irq_n = ie & xr_n;
        else
            irq_n = irq & ie;
        if (start)
            err_n = 1'b0;
        else if (state_n == ERR)
            err_n = 1'b1;
        else
            err_n = err;
    end
endmodule

// File: tb/tb_camac_cycle_sequencer.sv
// Directed self-checking bench for camac_cycle_sequencer (default and narrow-timing instances).
module tb_camac_cycle_sequencer;
    logic       clk = 1'b0;
    logic       reset, w, sel, tim, ie, cx1;
    logic [1:0] a;
    logic [2:0] a2;
    logic       rdy, c1, c2, sel2, xr, irq, err;
    logic [3:0] x;
    logic       rdy2, c1b, c2b, sel2b, xr2, irq2, err2;
    logic [7:0] x2;
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    camac_cycle_sequencer dut (
        .clk(clk), .reset(reset), .a(a), .w(w), .sel(sel), .tim(tim), .ie(ie), .cx1(cx1),
        .rdy(rdy), .c1(c1), .c2(c2), .sel2(sel2), .x(x), .xr(xr), .irq(irq), .err(err)
    );

    camac_cycle_sequencer #(
        .ADDR_WIDTH(3), .C1_CYCLES(1), .GAP_CYCLES(1), .C2_CYCLES(1), .TIMEOUT_CYCLES(16)
    ) dut2 (
        .clk(clk), .reset(reset), .a(a2), .w(w), .sel(sel), .tim(tim), .ie(ie), .cx1(cx1),
        .rdy(rdy2), .c1(c1b), .c2(c2b), .sel2(sel2b), .x(x2), .xr(xr2), .irq(irq2), .err(err2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; sel = 1'b1; tim = 1'b0; w = 1'b0; ie = 1'b0; cx1 = 1'b0;
        a = '0; a2 = '0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_rdy", 32'(rdy), 32'd1);
        chk("rst_c1", 32'(c1), 32'd0);
        chk("rst_c2", 32'(c2), 32'd0);
        chk("rst_sel2", 32'(sel2), 32'd0);
        chk("rst_x", 32'(x), 32'd0);
        chk("rst_xr", 32'(xr), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        tick();
        chk("idle_rdy", 32'(rdy), 32'd1);

        // Write cycle, a=2
        a = 2'd2; w = 1'b1; tim = 1'b1; sel = 1'b0;
        tick();
        chk("wr_e0_rdy", 32'(rdy), 32'd0);
        chk("wr_e0_x", 32'(x), 32'h4);
        chk("wr_e0_sel2", 32'(sel2), 32'd1);
        chk("wr_e0_c1", 32'(c1), 32'd0);
        for (int k = 1; k <= 12; k++) begin
            if (k == 2) a = 2'd0;
            tick();
            chk("wr_c1", 32'(c1), 32'(k >= 1 && k < 5));
            chk("wr_c2", 32'(c2), 32'(k >= 7 && k < 11));
            chk("wr_rdy", 32'(rdy), 32'(k >= 11));
            chk("wr_x", 32'(x), 32'h4);
        end
        sel = 1'b1;
        tick();
        chk("wr_end_sel2", 32'(sel2), 32'd0);
        chk("wr_end_x", 32'(x), 32'd0);
        chk("wr_end_rdy", 32'(rdy), 32'd1);
        chk("wr_end_irq", 32'(irq), 32'd0);
        tick();

        // Read cycle, a=1, X response and interrupt
        a = 2'd1; w = 1'b0; cx1 = 1'b1; ie = 1'b1; tim = 1'b1; sel = 1'b0;
        tick();
        chk("rd_e0_x", 32'(x), 32'h2);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("rd_c1", 32'(c1), 32'(k < 5));
            chk("rd_c2", 32'(c2), 32'd0);
            chk("rd_rdy", 32'(rdy), 32'(k >= 7));
            if (k == 7) begin
                chk("rd_xr", 32'(xr), 32'd1);
                chk("rd_irq", 32'(irq), 32'd1);
            end
        end
        ie = 1'b0;
        tick();
        chk("rd_irq_clr", 32'(irq), 32'd0);
        chk("rd_xr_hold", 32'(xr), 32'd1);
        sel = 1'b1; cx1 = 1'b0;
        tick();
        chk("rd_end_sel2", 32'(sel2), 32'd0);

        // Timeout
        tim = 1'b0; sel = 1'b0;
        tick();
        chk("to_e0_rdy", 32'(rdy), 32'd0);
        for (int k = 1; k <= 17; k++) begin
            tick();
            chk("to_err", 32'(err), 32'(k >= 16));
            chk("to_rdy", 32'(rdy), 32'(k >= 16));
            chk("to_c1", 32'(c1), 32'd0);
            chk("to_c2", 32'(c2), 32'd0);
        end
        chk("to_sel2", 32'(sel2), 32'd1);
        sel = 1'b1;
        tick();
        chk("to_end_sel2", 32'(sel2), 32'd0);
        chk("to_end_x", 32'(x), 32'd0);
        chk("to_end_err", 32'(err), 32'd1);

        // Abort in WAIT_DW
        sel = 1'b0;
        tick();
        chk("ab_e0_err", 32'(err), 32'd0);
        chk("ab_e0_rdy", 32'(rdy), 32'd0);
        tick(); tick();
        sel = 1'b1;
        tick();
        chk("ab_rdy", 32'(rdy), 32'd1);
        chk("ab_sel2", 32'(sel2), 32'd0);
        chk("ab_x", 32'(x), 32'd0);
        chk("ab_err", 32'(err), 32'd0);
        chk("ab_c1", 32'(c1), 32'd0);

        // sel released during STROBE1: strobe and gap still complete
        a = 2'd3; w = 1'b0; tim = 1'b1; sel = 1'b0;
        tick();
        tick();
        chk("sa_e1_c1", 32'(c1), 32'd1);
        sel = 1'b1;
        for (int k = 2; k <= 7; k++) begin
            tick();
            chk("sa_c1", 32'(c1), 32'(k < 5));
            chk("sa_rdy", 32'(rdy), 32'(k >= 7));
            chk("sa_sel2", 32'(sel2), 32'd1);
        end
        tick();
        chk("sa_end_sel2", 32'(sel2), 32'd0);
        chk("sa_end_x", 32'(x), 32'd0);
        chk("sa_end_c2", 32'(c2), 32'd0);

        // Reset during STROBE2
        a = 2'd0; w = 1'b1; tim = 1'b1; sel = 1'b0;
        tick();
        for (int k = 1; k <= 8; k++) tick();
        chk("rs_c2_pre", 32'(c2), 32'd1);
        reset = 1'b1;
        tick();
        chk("rs_c2", 32'(c2), 32'd0);
        chk("rs_rdy", 32'(rdy), 32'd1);
        chk("rs_x", 32'(x), 32'd0);
        chk("rs_sel2", 32'(sel2), 32'd0);
        reset = 1'b0; sel = 1'b1;
        tick();
        chk("rs_idle_rdy", 32'(rdy), 32'd1);

        // Narrow-timing instance, write a=7
        a2 = 3'd7; w = 1'b1; tim = 1'b1; sel = 1'b0;
        tick();
        chk("n_e0_x", 32'(x2), 32'h80);
        chk("n_e0_rdy", 32'(rdy2), 32'd0);
        a2 = 3'd0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("n_c1", 32'(c1b), 32'(k == 1));
            chk("n_c2", 32'(c2b), 32'(k == 3));
            chk("n_rdy", 32'(rdy2), 32'(k >= 4));
            chk("n_x", 32'(x2), 32'h80);
        end
        sel = 1'b1;
        tick();
        chk("n_end_x", 32'(x2), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
